tpn_drain: RTL and testbench
============================

TPN_DRAIN -- requirements
Module: tpn_drain

Interface
REQ-001 SHALL have clk input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have rst input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have in_valid input, 1 bit: the per-block match record is valid.
REQ-004 SHALL have in_ready output, 1 bit: the block can accept a record.
REQ-005 SHALL have in_tpn_arr input, 768 bits (NOP_WIDTH*PPB): packed 12-bit true page numbers, entry 0 at bits [11:0].
REQ-006 SHALL have in_cnt input, 7 bits: number of valid entries in in_tpn_arr, range 0..64.
REQ-007 SHALL have in_last input, 1 bit: the record is the final block (b_idx 63) of a scan.
REQ-008 SHALL have out_valid output, 1 bit: out_tpn holds a valid page number.
REQ-009 SHALL have out_ready input, 1 bit: the consumer accepts out_tpn.
REQ-010 SHALL have out_tpn output, 12 bits: a global true page number, 0..4095.
REQ-011 SHALL have out_last output, 1 bit: out_tpn is the final TPN of the scan.
REQ-012 SHALL have scan_done output, 1 bit: one-cycle pulse at scan completion.
REQ-013 SHALL have total_cnt output, 13 bits: TPNs accepted in the current scan, 0..4096.

Function
REQ-014 SHALL implement the FSM states IDLE and DRAIN.
REQ-015 SHALL drive in_ready=1 exactly when the state is IDLE, with in_ready depending on no input combinationally.
REQ-016 SHALL, on in_valid&&in_ready with in_cnt>0, capture in_tpn_arr, min(in_cnt,64) and in_last, then enter DRAIN.
REQ-017 SHALL assert out_valid in the cycle after capture, with out_tpn equal to entry 0 (latency 1).
REQ-018 SHALL, on out_valid&&out_ready, shift the held array right by 12 bits, decrement the remaining count and increment total_cnt.
REQ-019 SHALL hold out_valid, out_tpn and out_last stable while out_valid=1 and out_ready=0.
REQ-020 SHALL assert out_last only with the last remaining entry of a record captured with in_last=1.
REQ-021 SHALL return to IDLE when the final entry is accepted, so in_ready rises on the next cycle; throughput is one record per in_cnt+1 cycles.
REQ-022 SHALL treat in_cnt=0 as a record with no output and stay in IDLE; if in_last=1, it pulses scan_done on the next cycle.
REQ-023 SHALL pulse scan_done for one cycle in the cycle after the out_last entry is accepted.
REQ-024 SHALL clip in_cnt values above 64 to 64.
REQ-025 SHALL clear total_cnt to 0 on the first capture following a scan_done pulse; otherwise total_cnt saturates at 4096.

Reset
REQ-026 SHALL, on rst=0, immediately force: state IDLE, out_valid=0, out_tpn=0, out_last=0, scan_done=0, total_cnt=0, held array and count=0, in_ready=1 after release.
REQ-027 SHALL discard any partially drained record on reset mid-DRAIN, with no scan_done pulse.

Configuration
REQ-028 SHALL compile in the TPN_DRAIN_STATS_EN macro: when defined, total_cnt behaves per REQ-018/REQ-025; when undefined, total_cnt is tied to 0 and its counter is removed.

Structure
REQ-029 SHALL take NOP=4096, P_SIZE=12, PPB=64, NOB=64, NOP_WIDTH=12, B_SIZE=768 and a tpn_t (12-bit) typedef from the shared package bloom_pkg.
REQ-030 SHALL place the record holding register and shifter in one sub-module, tpn_shift_reg; the FSM and counters stay in tpn_drain.

Verification
REQ-031 SHALL cover: in_cnt=2, entries {0x040,0x07F}, in_last=0, out_ready=1 -> out_tpn 0x040 then 0x07F on consecutive cycles, out_last=0, in_ready high on cycle 3.
REQ-032 SHALL cover: in_cnt=1, entry 0xFFF, in_last=1 -> out_tpn=0xFFF with out_last=1, scan_done pulse on the next cycle, total_cnt=1.
REQ-033 SHALL cover: in_cnt=3 with out_ready=0 for 5 cycles -> out_tpn stable at entry 0 for all 5 cycles and total_cnt unchanged.
REQ-034 SHALL cover: in_cnt=0, in_last=1 -> no out_valid, scan_done pulse 1 cycle after capture, state remains IDLE.
REQ-035 SHALL cover: in_cnt=100, all entries valid -> exactly 64 TPNs emitted.
REQ-036 SHALL cover: rst asserted after 2 of 4 TPNs accepted -> all outputs 0 immediately, next record drains from its entry 0, total_cnt restarts at 0.

Source files
------------

// File: rtl/bloom_pkg.sv
// Shared constants and types for the bloom/TPN datapath.
// Sizes for the page-number records and the drain FSM state type.
package bloom_pkg;

    localparam int NOP       = 4096;
    localparam int P_SIZE    = 12;
    localparam int PPB       = 64;
    localparam int NOB       = 64;
    localparam int NOP_WIDTH = 12;
    localparam int B_SIZE    = 768;
    localparam int CNT_W     = 7;
    localparam int TOTAL_W   = 13;

    typedef logic [NOP_WIDTH-1:0] tpn_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Records never hold more than PPB entries; larger counts are clipped.
    function automatic logic [CNT_W-1:0] clip_cnt(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(PPB)) ? CNT_W'(PPB) : c;
    endfunction

endpackage

// File: rtl/tpn_shift_reg.sv
// Holding register for one block record: loads the packed TPN array and
// shifts it out one 12-bit entry at a time, tracking the remaining count.
module tpn_shift_reg
    import bloom_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [B_SIZE-1:0] arr_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              last_i,
    output tpn_t              head_o,
    output logic [CNT_W-1:0]  remain_o,
    output logic              last_o
);

    logic [B_SIZE-1:0] arr_q, arr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;

    always_comb begin
        arr_d  = arr_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (load_i) begin
            arr_d  = arr_i;
            cnt_d  = cnt_i;
            last_d = last_i;
        end else if (shift_i && (cnt_q != '0)) begin
            arr_d = arr_q >> NOP_WIDTH;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr_q  <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            arr_q  <= arr_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign head_o   = arr_q[NOP_WIDTH-1:0];
    assign remain_o = cnt_q;
    // Only the final remaining entry of a last-block record carries the flag.
    assign last_o   = last_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/tpn_drain.sv
// Drains per-block match records into a stream of single TPNs.
// Optional TPN_DRAIN_STATS_EN macro enables the per-scan total_cnt counter.
module tpn_drain
    import bloom_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [B_SIZE-1:0]  in_tpn_arr,
    input  logic [CNT_W-1:0]   in_cnt,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output tpn_t               out_tpn,
    output logic               out_last,
    output logic               scan_done,
    output logic [TOTAL_W-1:0] total_cnt,
    output drain_state_e       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits for ready, and out_* holds steady until accepted.
    drain_state_e     state_q;
    logic             scan_done_q;
    logic             in_fire, capture, out_fire, final_fire, set_done;
    tpn_t             head;
    logic [CNT_W-1:0] remain;
    logic             head_last;

    assign in_ready   = (state_q == IDLE);
    assign in_fire    = in_valid && in_ready;
    assign capture    = in_fire && (in_cnt != '0);
    assign out_valid  = (state_q == DRAIN);
    assign out_fire   = out_valid && out_ready;
    assign final_fire = out_fire && (remain == CNT_W'(1));
    assign set_done   = (in_fire && (in_cnt == '0) && in_last) ||
                        (final_fire && head_last);

    tpn_shift_reg u_shift (
        .clk      (clk),
        .rst      (rst),
        .load_i   (capture),
        .shift_i  (out_fire),
        .arr_i    (in_tpn_arr),
        .cnt_i    (clip_cnt(in_cnt)),
        .last_i   (in_last),
        .head_o   (head),
        .remain_o (remain),
        .last_o   (head_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= set_done;
            case (state_q)
                IDLE:    if (capture) state_q <= DRAIN;
                DRAIN:   if (final_fire) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_tpn   = head;
    assign out_last  = out_valid && head_last;
    assign scan_done = scan_done_q;
    assign dbg_state = state_q;

`ifdef TPN_DRAIN_STATS_EN
    logic [TOTAL_W-1:0] total_q;
    logic               clear_pend_q;

    // The count of a finished scan stays visible until the next scan starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q      <= '0;
            clear_pend_q <= 1'b0;
        end else if (capture && clear_pend_q) begin
            total_q      <= '0;
            clear_pend_q <= 1'b0;
        end else begin
            if (set_done) clear_pend_q <= 1'b1;
            if (out_fire && (total_q < TOTAL_W'(NOP))) total_q <= total_q + TOTAL_W'(1);
        end
    end

    assign total_cnt = total_q;
`else
    assign total_cnt = '0;
`endif

endmodule

// File: tb/tb_tpn_drain.sv
// Self-checking bench for tpn_drain: directed corner cases plus random
// traffic compared against a queue-based model of the emitted TPN stream.
`timescale 1ns/1ps
module tb_tpn_drain;
  import bloom_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [B_SIZE-1:0]   in_tpn_arr = '0;
  logic [CNT_W-1:0]    in_cnt = '0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  tpn_t                out_tpn;
  logic                out_last;
  logic                scan_done;
  logic [TOTAL_W-1:0]  total_cnt;
  drain_state_e        dbg_state;

  always #5 clk = ~clk;

  tpn_drain dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tpn_arr (in_tpn_arr),
    .in_cnt     (in_cnt),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tpn    (out_tpn),
    .out_last   (out_last),
    .scan_done  (scan_done),
    .total_cnt  (total_cnt),
    .dbg_state  (dbg_state)
  );

  // Reference model: pending output stream of {last, tpn} plus scan bookkeeping.
  logic [12:0] exp_q[$];
  int          m_total = 0;
  bit          m_sd = 1'b0;
  bit          m_pend = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_total();
`ifdef TPN_DRAIN_STATS_EN
    return m_total;
`else
    return 0;
`endif
  endfunction

  function automatic logic [B_SIZE-1:0] rand_arr();
    logic [B_SIZE-1:0] a;
    a = '0;
    for (int i = 0; i < PPB; i++) a[i*12 +: 12] = 12'($urandom_range(0, 4095));
    return a;
  endfunction

  task automatic check_outputs();
    bit busy;
    busy = (exp_q.size() != 0);
    check("in_ready",  32'(in_ready),  32'(!busy));
    check("out_valid", 32'(out_valid), 32'(busy));
    check("state",     32'(dbg_state == DRAIN), 32'(busy));
    if (busy) begin
      check("out_tpn",  32'(out_tpn),  32'(exp_q[0][11:0]));
      check("out_last", 32'(out_last), 32'(exp_q[0][12]));
    end
    check("scan_done", 32'(scan_done), 32'(m_sd));
    check("total_cnt", 32'(total_cnt), 32'(exp_total()));
  endtask

  // Called at a falling edge: check, drive inputs, advance the model by one clock.
  task automatic step(input bit v, input logic [B_SIZE-1:0] arr, input int cnt,
                      input bit last, input bit ordy);
    int          n;
    logic [12:0] e;
    bit          sd_next;
    check_outputs();
    in_valid   = v;
    in_tpn_arr = arr;
    in_cnt     = 7'(cnt);
    in_last    = last;
    out_ready  = ordy;
    sd_next    = 1'b0;
    if (exp_q.size() != 0) begin
      if (ordy) begin
        e = exp_q.pop_front();
        if (m_total < 4096) m_total++;
        if (e[12]) begin
          sd_next = 1'b1;
          m_pend  = 1'b1;
        end
      end
    end else if (v) begin
      n = (cnt > 64) ? 64 : cnt;
      if (n == 0) begin
        if (last) begin
          sd_next = 1'b1;
          m_pend  = 1'b1;
        end
      end else begin
        if (m_pend) begin
          m_total = 0;
          m_pend  = 1'b0;
        end
        for (int i = 0; i < n; i++) exp_q.push_back({last && (i == n - 1), arr[i*12 +: 12]});
      end
    end
    m_sd = sd_next;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, 0, 1'b0, ordy);
  endtask

  task automatic drain(output int acc);
    acc = 0;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      if (out_valid) acc++;
      idle(1'b1);
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_tpn",   32'(out_tpn),   32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    check("rst_total_cnt", 32'(total_cnt), 32'd0);
    exp_q.delete();
    m_total   = 0;
    m_sd      = 1'b0;
    m_pend    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [B_SIZE-1:0] arr;
    int acc;
    #2;
    do_reset();

    // Single last-block entry: out_last, scan_done next cycle, total 1.
    arr = rand_arr();
    arr[11:0] = 12'hFFF;
    step(1'b1, arr, 1, 1'b1, 1'b1);
    drain(acc);
    idle(1'b1);

    // Two entries, consumer always ready.
    arr = rand_arr();
    arr[11:0]  = 12'h040;
    arr[23:12] = 12'h07F;
    step(1'b1, arr, 2, 1'b0, 1'b1);
    drain(acc);
    check("two_entry_count", 32'(acc), 32'd2);
    idle(1'b1);

    // Backpressure: three entries held for five cycles.
    step(1'b1, rand_arr(), 3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    drain(acc);

    // Empty last-block record: scan_done only.
    step(1'b1, rand_arr(), 0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Oversized count clipped to 64 entries.
    step(1'b1, rand_arr(), 100, 1'b1, 1'b1);
    drain(acc);
    check("clip_count", 32'(acc), 32'd64);
    idle(1'b1);

    // Reset after two of four entries, then a fresh record.
    step(1'b1, rand_arr(), 4, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    do_reset();
    step(1'b1, rand_arr(), 4, 1'b1, 1'b1);
    drain(acc);
    idle(1'b1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      int sel, cnt;
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      cnt = 0;
      else if (sel == 1) cnt = 64;
      else if (sel == 2) cnt = int'($urandom_range(65, 127));
      else               cnt = int'($urandom_range(1, 8));
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 3) != 0, rand_arr(), cnt,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end
    drain(acc);
    idle(1'b1);

    // Saturation: 66 full records in one scan exceed 4096 TPNs.
    do_reset();
    for (int r = 0; r < 66; r++) begin
      step(1'b1, rand_arr(), 64, 1'b0, 1'b1);
      drain(acc);
    end
    idle(1'b1);
    check("total_saturated", 32'(total_cnt), 32'(exp_total()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
